// File: rtl/maj_triplet_sampler.sv
// Serial front end: finds frame starts and captures three samples around mid-bit per data/stop bit.
// Latency: rx_in to rx_s is 2 cycles; a triplet is presented at cnt==M+2 of its bit.
// Backpressure: none; enable low aborts the current frame and blocks new ones.
module maj_triplet_sampler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       enable,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       trip_valid,
    output logic [3:0] bit_idx,
    output logic       frame_done,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_MIDM = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_MIDP = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [3:0] IDX_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] IDX_STOP      = 4'(DATA_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          rx_m;
    logic          rx_s;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            x          <= 1'b1;
            y          <= 1'b1;
            z          <= 1'b1;
            bit_idx    <= 4'd0;
            trip_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rx_m       <= rx_in;
            rx_s       <= rx_m;
            trip_valid <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (enable && !rx_s) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_MID && rx_s) begin
                        // line went back high before mid-bit: treat as noise
                        state <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_DATA;
                        cnt     <= '0;
                        bit_idx <= 4'd0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_DATA: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else begin
                        if (cnt == CNT_MIDM) x <= rx_s;
                        if (cnt == CNT_MID)  y <= rx_s;
                        if (cnt == CNT_MIDP) begin
                            z          <= rx_s;
                            trip_valid <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (bit_idx == IDX_LAST_DATA) begin
                                state   <= ST_STOP;
                                bit_idx <= IDX_STOP;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end

                ST_STOP: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else begin
                        if (cnt == CNT_MIDM) x <= rx_s;
                        if (cnt == CNT_MID)  y <= rx_s;
                        // stop bit is cut short so a back-to-back start edge is not missed
                        if (cnt == CNT_MIDP) begin
                            z          <= rx_s;
                            trip_valid <= 1'b1;
                            frame_done <= 1'b1;
                            state      <= ST_IDLE;
                        end
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maj_triplet_sampler.sv
// Scoreboard bench for maj_triplet_sampler: expected triplets queued as frames are driven.
module tb_maj_triplet_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       enable;
    logic       x, y, z;
    logic       trip_valid;
    logic [3:0] bit_idx;
    logic       frame_done;
    logic       busy;

    always #5 clk = ~clk;

    maj_triplet_sampler #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .enable     (enable),
        .x          (x),
        .y          (y),
        .z          (z),
        .trip_valid (trip_valid),
        .bit_idx    (bit_idx),
        .frame_done (frame_done),
        .busy       (busy)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         n_tv = 0;
    int         n_fd = 0;
    int         cyc = 0;
    int         last_tv_cyc = 0;
    logic       prev_tv = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc++;

    // triplet word: {frame_done, bit_idx[3:0], x, y, z}
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            if (trip_valid) begin
                n_tv++;
                check_val("tv_consecutive", 32'(prev_tv), 0);
                if (exp_q.size() == 0) begin
                    check_val("trip_expected", 32'(exp_q.size() != 0), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("triplet", {24'd0, frame_done, bit_idx, x, y, z}, {24'd0, e});
                    if (e[6:3] != 4'd0) check_val("tv_spacing", cyc - last_tv_cyc, 16);
                end
                last_tv_cyc = cyc;
            end
            if (frame_done) begin
                n_fd++;
                check_val("fd_with_tv", 32'(trip_valid), 1);
            end
        end
        prev_tv = trip_valid;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rx_in = 1'b1;
        end
    endtask

    // cut_bit >= 0: drop enable (or pulse rst) 4 clocks into that bit
    task automatic drive_frame(input logic [7:0] data, input int glitch_bit, input int stop_len,
                               input int cut_bit, input bit cut_is_reset);
        logic [8:0] bits;
        int         nb;
        int         bi;
        int         off;
        logic       bv;
        logic       v;
        bits = {1'b1, data};
        nb = (cut_bit < 0) ? 9 : cut_bit;
        for (int b = 0; b < nb; b++) begin
            bv = bits[b];
            exp_q.push_back({(b == 8), 4'(b), bv, bv ^ (b == glitch_bit), bv});
        end
        for (int t = 0; t < 16 + 16 * 8 + stop_len; t++) begin
            bi  = t / 16 - 1;
            off = t % 16;
            if (t < 16) begin
                v = 1'b0;
            end else begin
                v = bits[bi];
                if (bi == glitch_bit && off == 9) v = ~v;
            end
            @(posedge clk); #1;
            rx_in = v;
            if (cut_bit >= 0 && bi == cut_bit && off == 4) begin
                if (cut_is_reset) rst = 1'b1;
                else enable = 1'b0;
                @(posedge clk); #1;
                rx_in = 1'b1;
                @(negedge clk);
                check_val("cut_busy", 32'(busy), 0);
                check_val("cut_trip_valid", 32'(trip_valid), 0);
                check_val("cut_frame_done", 32'(frame_done), 0);
                if (cut_is_reset) begin
                    check_val("rst_xyz", {29'd0, x, y, z}, 7);
                    check_val("rst_bit_idx", 32'(bit_idx), 0);
                end else begin
                    check_val("abort_bit_idx", 32'(bit_idx), cut_bit);
                end
                rst = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        int n0;
        int f0;
        int busy_cyc;

        rst    = 1'b1;
        enable = 1'b1;
        rx_in  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_xyz", {29'd0, x, y, z}, 7);
        check_val("reset_bit_idx", 32'(bit_idx), 0);
        check_val("reset_trip_valid", 32'(trip_valid), 0);
        check_val("reset_frame_done", 32'(frame_done), 0);
        check_val("reset_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);

        // clean frame
        n0 = n_tv; f0 = n_fd;
        drive_frame(8'hA5, -1, 16, -1, 1'b0);
        idle(20);
        check_val("clean_trips", n_tv - n0, 9);
        check_val("clean_frames", n_fd - f0, 1);

        // single-cycle glitch on the y sample of bit 3
        n0 = n_tv;
        drive_frame(8'h00, 3, 16, -1, 1'b0);
        idle(20);
        check_val("glitch_trips", n_tv - n0, 9);

        // false start
        n0 = n_tv; f0 = n_fd; busy_cyc = 0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            rx_in = (t < 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (busy) busy_cyc++;
        end
        check_val("false_start_busy_cycles", busy_cyc, 9);
        check_val("false_start_trips", n_tv - n0, 0);
        check_val("false_start_frames", n_fd - f0, 0);

        // abort during bit 4
        n0 = n_tv; f0 = n_fd;
        drive_frame(8'h96, -1, 16, 4, 1'b0);
        idle(40);
        check_val("abort_bit_idx_hold", 32'(bit_idx), 4);
        enable = 1'b1;
        idle(10);
        check_val("abort_trips", n_tv - n0, 4);
        check_val("abort_frames", n_fd - f0, 0);

        // reset during bit 2, then a clean frame
        n0 = n_tv; f0 = n_fd;
        drive_frame(8'hFF, -1, 16, 2, 1'b1);
        idle(30);
        drive_frame(8'h3C, -1, 16, -1, 1'b0);
        idle(20);
        check_val("reset_mid_trips", n_tv - n0, 11);
        check_val("reset_mid_frames", n_fd - f0, 1);

        // back-to-back frames: second start right after stop-bit z sample
        n0 = n_tv; f0 = n_fd;
        drive_frame(8'h5A, -1, 11, -1, 1'b0);
        drive_frame(8'hC3, -1, 16, -1, 1'b0);
        idle(20);
        check_val("b2b_trips", n_tv - n0, 18);
        check_val("b2b_frames", n_fd - f0, 2);

        check_val("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
